xed_decoder_10: RTL and testbench

Sequential check-and-correct stage that consumes one 8-chip XED codeword: 8×16-byte chip data, 8 per-chip CRC-8 codes, the 16-byte simple-XOR parity block and its CRC. It sits directly downstream of the XED encoder/storage path. It checks one CRC per cycle, locates a single failed chip, rebuilds that chip from the parity block, and re-verifies the rebuilt chip. It returns corrected data with a status code over a valid/ready handshake.

---
 rtl/xed_decoder_10.sv | 221 ++++++++++++++++++++++
 tb/tb_xed_decoder_10.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xed_decoder_10.sv
// rtl/xed_decoder_10.sv - XED codeword check-and-correct stage: per-chip CRC check, single-chip rebuild, re-verify

module xed_crc8_128 (
    input  logic [127:0] data,
    output logic [7:0]   crc
);

    function automatic logic [7:0] crc8(input logic [127:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int b = 15; b >= 0; b--) begin
            c = c ^ d[b*8 +: 8];
            for (int j = 0; j < 8; j++) begin
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
            end
        end
        return ~c;
    endfunction

    assign crc = crc8(data);

endmodule

module xed_decoder_10 (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] chip_data,
    input  logic [63:0]   chip_crc,
    input  logic [127:0]  xor_parity,
    input  logic [7:0]    parity_crc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] out_data,
    output logic [1:0]    status,
    output logic [2:0]    err_chip,
    output logic [15:0]   corr_cnt,
    output logic [15:0]   uncorr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CORRECT,
        S_VERIFY,
        S_OUT
    } state_t;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;
    localparam logic [1:0] ST_PAR    = 2'b11;

    state_t         state;
    state_t         state_nxt;

    logic [1023:0]  data_r;
    logic [63:0]    crc_r;
    logic [127:0]   par_r;
    logic [7:0]     pcrc_r;
    logic [7:0]     fail_r;
    logic           pfail_r;
    logic [127:0]   syn_r;
    logic [127:0]   orig_r;
    logic [3:0]     idx_r;
    logic [1:0]     status_r;
    logic [2:0]     err_r;
    logic [15:0]    corr_r;
    logic [15:0]    uncorr_r;

    logic [2:0]     sel;
    logic [127:0]   cur_chip;
    logic [127:0]   crc_in;
    logic [7:0]     crc_exp;
    logic [7:0]     crc_calc;
    logic           crc_mismatch;
    logic [3:0]     fail_cnt;
    logic [2:0]     fail_low;
    logic           verify_fail;
    logic [1:0]     final_status;

    // One CRC engine shared by CHECK (chip idx / parity block) and VERIFY (rebuilt chip)
    always_comb begin
        sel      = (state == S_VERIFY) ? err_r : idx_r[2:0];
        cur_chip = data_r[{sel, 7'd0} +: 128];
        crc_in   = cur_chip;
        crc_exp  = crc_r[{sel, 3'd0} +: 8];
        if (state == S_CHECK && idx_r[3]) begin
            crc_in  = par_r;
            crc_exp = pcrc_r;
        end
    end

    xed_crc8_128 u_crc (
        .data (crc_in),
        .crc  (crc_calc)
    );

    assign crc_mismatch = (crc_calc != crc_exp);

    always_comb begin
        fail_cnt = 4'd0;
        fail_low = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (fail_r[i]) begin
                fail_cnt = fail_cnt + 4'd1;
                fail_low = 3'(i);
            end
        end
    end

    assign verify_fail  = (state == S_VERIFY) && (status_r == ST_CORR) && crc_mismatch;
    assign final_status = verify_fail ? ST_UNCORR : status_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (in_valid) state_nxt = S_CHECK;
            S_CHECK:   if (idx_r == 4'd8) state_nxt = S_CORRECT;
            S_CORRECT: state_nxt = S_VERIFY;
            S_VERIFY:  state_nxt = S_OUT;
            S_OUT:     if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= '0;
            crc_r    <= '0;
            par_r    <= '0;
            pcrc_r   <= '0;
            fail_r   <= '0;
            pfail_r  <= 1'b0;
            syn_r    <= '0;
            orig_r   <= '0;
            idx_r    <= '0;
            status_r <= ST_CLEAN;
            err_r    <= '0;
            corr_r   <= '0;
            uncorr_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data_r   <= chip_data;
                        crc_r    <= chip_crc;
                        par_r    <= xor_parity;
                        pcrc_r   <= parity_crc;
                        fail_r   <= '0;
                        pfail_r  <= 1'b0;
                        syn_r    <= '0;
                        idx_r    <= '0;
                        status_r <= ST_CLEAN;
                        err_r    <= '0;
                    end
                end
                S_CHECK: begin
                    idx_r <= idx_r + 4'd1;
                    if (!idx_r[3]) begin
                        fail_r[idx_r[2:0]] <= crc_mismatch;
                        syn_r              <= syn_r ^ cur_chip;
                    end else begin
                        pfail_r <= crc_mismatch;
                        syn_r   <= syn_r ^ par_r;
                    end
                end
                S_CORRECT: begin
                    if (fail_cnt == 4'd0) begin
                        err_r <= 3'd0;
                        if (pfail_r)
                            status_r <= ST_PAR;
                        else if (syn_r != '0)
                            status_r <= ST_UNCORR;
                        else
                            status_r <= ST_CLEAN;
                    end else if (fail_cnt == 4'd1 && !pfail_r) begin
                        // chip ^ syndrome equals the XOR of the other seven chips and the parity block
                        status_r <= ST_CORR;
                        err_r    <= fail_low;
                        orig_r   <= data_r[{fail_low, 7'd0} +: 128];
                        data_r[{fail_low, 7'd0} +: 128] <= data_r[{fail_low, 7'd0} +: 128] ^ syn_r;
                    end else begin
                        status_r <= ST_UNCORR;
                        err_r    <= fail_low;
                    end
                end
                S_VERIFY: begin
                    if (verify_fail) begin
                        status_r <= ST_UNCORR;
                        data_r[{err_r, 7'd0} +: 128] <= orig_r;
                    end
                    if (final_status == ST_CORR && corr_r != 16'hFFFF)
                        corr_r <= corr_r + 16'd1;
                    if (final_status == ST_UNCORR && uncorr_r != 16'hFFFF)
                        uncorr_r <= uncorr_r + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE) && !rst;
    assign out_valid  = (state == S_OUT);
    assign out_data   = data_r;
    assign status     = status_r;
    assign err_chip   = err_r;
    assign corr_cnt   = corr_r;
    assign uncorr_cnt = uncorr_r;

endmodule

// File: tb/tb_xed_decoder_10.sv
// tb/tb_xed_decoder_10.sv - randomized and directed bench for xed_decoder_10 against a behavioural model

module tb_xed_decoder_10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] chip_data;
    logic [63:0]   chip_crc;
    logic [127:0]  xor_parity;
    logic [7:0]    parity_crc;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] out_data;
    logic [1:0]    status;
    logic [2:0]    err_chip;
    logic [15:0]   corr_cnt;
    logic [15:0]   uncorr_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1023:0] exp_data;
    logic [1:0]    exp_status;
    logic [2:0]    exp_err;
    logic [15:0]   exp_corr;
    logic [15:0]   exp_uncorr;
    bit            exp_pending;

    xed_decoder_10 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .chip_data  (chip_data),
        .chip_crc   (chip_crc),
        .xor_parity (xor_parity),
        .parity_crc (parity_crc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .status     (status),
        .err_chip   (err_chip),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bitwise MSB-first CRC over the whole 128-bit block
    function automatic logic [7:0] m_crc(input logic [127:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return ~c;
    endfunction

    task automatic make_clean(input logic [1023:0] d, output logic [63:0] cc,
                              output logic [127:0] p, output logic [7:0] pc);
        p = '0;
        for (int i = 0; i < 8; i++) begin
            cc[i*8 +: 8] = m_crc(d[i*128 +: 128]);
            p = p ^ d[i*128 +: 128];
        end
        pc = m_crc(p);
    endtask

    task automatic model(input logic [1023:0] d, input logic [63:0] cc, input logic [127:0] p,
                         input logic [7:0] pc, output logic [1023:0] od, output logic [1:0] st,
                         output logic [2:0] er);
        int           k;
        int           low;
        logic [127:0] syn;
        logic [127:0] rb;
        logic         pf;
        k   = 0;
        low = -1;
        syn = p;
        for (int i = 0; i < 8; i++) begin
            syn = syn ^ d[i*128 +: 128];
            if (m_crc(d[i*128 +: 128]) != cc[i*8 +: 8]) begin
                k++;
                if (low < 0) low = i;
            end
        end
        pf = (m_crc(p) != pc);
        od = d;
        st = 2'd0;
        er = 3'd0;
        if (k == 0) begin
            st = pf ? 2'd3 : ((syn != '0) ? 2'd2 : 2'd0);
        end else if (k == 1 && !pf) begin
            rb = p;
            for (int j = 0; j < 8; j++)
                if (j != low) rb = rb ^ d[j*128 +: 128];
            er = 3'(low);
            if (m_crc(rb) == cc[low*8 +: 8]) begin
                od[low*128 +: 128] = rb;
                st = 2'd1;
            end else begin
                st = 2'd2;
            end
        end else begin
            st = 2'd2;
            er = 3'(low);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        int bad;
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            bad = 0;
            for (int i = 7; i >= 0; i--)
                if (act[i*128 +: 128] !== exp[i*128 +: 128]) bad = i;
            $display("FAIL %s: chip %0d got %h expected %h at %0t", nm, bad,
                     act[bad*128 +: 128], exp[bad*128 +: 128], $time);
        end
    endtask

    // Every cycle a result is presented, it must match the model
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_pending) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk_data("out_data", out_data, exp_data);
                chk("status", 64'(status), 64'(exp_status));
                chk("err_chip", 64'(err_chip), 64'(exp_err));
                chk("corr_cnt", 64'(corr_cnt), 64'(exp_corr));
                chk("uncorr_cnt", 64'(uncorr_cnt), 64'(exp_uncorr));
                chk("in_ready_low_during_out", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic accept_cw(input logic [1023:0] d, input logic [63:0] cc, input logic [127:0] p,
                             input logic [7:0] pc, output bit ok);
        logic [1023:0] od;
        logic [1:0]    st;
        logic [2:0]    er;
        int            w;
        model(d, cc, p, pc, od, st, er);
        @(negedge clk);
        chip_data  = d;
        chip_crc   = cc;
        xor_parity = p;
        parity_crc = pc;
        in_valid   = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        if (!ok) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            exp_data   = od;
            exp_status = st;
            exp_err    = er;
            if (st == 2'd1 && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
            if (st == 2'd2 && exp_uncorr != 16'hFFFF) exp_uncorr = exp_uncorr + 16'd1;
            exp_pending = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run(input logic [1023:0] d, input logic [63:0] cc, input logic [127:0] p,
                       input logic [7:0] pc, input int hold, input bit lit_en,
                       input logic [1:0] lit_st, input logic [2:0] lit_er,
                       input logic [1023:0] lit_data);
        logic [1023:0] od;
        logic [1:0]    st;
        logic [2:0]    er;
        bit            ok;
        bit            done;
        int            lat;
        if (lit_en) begin
            model(d, cc, p, pc, od, st, er);
            chk("model_pin_status", 64'(st), 64'(lit_st));
            chk("model_pin_err", 64'(er), 64'(lit_er));
            chk_data("model_pin_data", od, lit_data);
        end
        accept_cw(d, cc, p, pc, ok);
        if (ok) begin
            lat  = 0;
            done = 1'b0;
            while (!done && lat < 40) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (out_valid) done = 1'b1;
            end
            chk("latency", 64'(lat), 64'd11);
            if (done) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk("held_valid", 64'(out_valid), 64'd1);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready   = 1'b0;
                exp_pending = 1'b0;
                @(negedge clk);
                chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
                chk("out_valid_after_handshake", 64'(out_valid), 64'd0);
            end else begin
                exp_pending = 1'b0;
            end
        end
    endtask

    logic [1023:0] d0;
    logic [1023:0] d;
    logic [63:0]   cc0;
    logic [63:0]   cc;
    logic [127:0]  p0;
    logic [127:0]  p;
    logic [7:0]    pc0;
    logic [7:0]    pc;
    logic [7:0]    bv;
    bit            ok;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        chip_data   = '0;
        chip_crc    = '0;
        xor_parity  = '0;
        parity_crc  = '0;
        exp_data    = '0;
        exp_status  = '0;
        exp_err     = '0;
        exp_corr    = '0;
        exp_uncorr  = '0;
        exp_pending = 1'b0;

        repeat (3) @(negedge clk);
        chk("in_ready_during_rst", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk_data("rst_out_data", out_data, '0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_err_chip", 64'(err_chip), 64'd0);
        chk("rst_corr_cnt", 64'(corr_cnt), 64'd0);
        chk("rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

        for (int i = 0; i < 8; i++) begin
            bv = 8'(17 * i);
            d0[i*128 +: 128] = {16{bv}};
        end
        make_clean(d0, cc0, p0, pc0);

        run(d0, cc0, p0, pc0, 0, 1'b1, 2'b00, 3'd0, d0);

        d = d0;
        d[5*128] = ~d[5*128];
        run(d, cc0, p0, pc0, 1, 1'b1, 2'b01, 3'd5, d0);
        chk("t2_corr_cnt_literal", 64'(corr_cnt), 64'd1);

        d = d0;
        d[2*128 + 10]  = ~d[2*128 + 10];
        d[6*128 + 100] = ~d[6*128 + 100];
        run(d, cc0, p0, pc0, 0, 1'b1, 2'b10, 3'd2, d);
        chk("t3_uncorr_cnt_literal", 64'(uncorr_cnt), 64'd1);

        p = p0;
        p[64] = ~p[64];
        run(d0, cc0, p, pc0, 2, 1'b1, 2'b11, 3'd0, d0);
        chk("t4_corr_cnt_literal", 64'(corr_cnt), 64'd1);
        chk("t4_uncorr_cnt_literal", 64'(uncorr_cnt), 64'd1);

        d = d0;
        d[3*128 + 7] = ~d[3*128 + 7];
        cc = cc0;
        cc[3*8 +: 8] = m_crc(d[3*128 +: 128]);
        run(d, cc, p0, pc0, 0, 1'b1, 2'b10, 3'd0, d);

        run(d0, cc0, p0, pc0, 20, 1'b0, 2'b00, 3'd0, d0);

        // Reset while CHECK is at idx 4: codeword aborted, counters cleared
        accept_cw(d0, cc0, p0, pc0, ok);
        repeat (4) @(posedge clk);
        #1;
        rst         = 1'b1;
        exp_pending = 1'b0;
        exp_corr    = '0;
        exp_uncorr  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort_no_out_valid", 64'(out_valid), 64'd0);
        end
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_corr_cnt", 64'(corr_cnt), 64'd0);
        chk("abort_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

        for (int t = 0; t < 40; t++) begin
            int mode;
            int a;
            int b;
            int bt;
            for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
            make_clean(d, cc, p, pc);
            mode = $urandom_range(0, 7);
            a    = $urandom_range(0, 7);
            b    = (a + 1 + $urandom_range(0, 6)) % 8;
            bt   = $urandom_range(0, 127);
            case (mode)
                1: d[a*128 + bt] = ~d[a*128 + bt];
                2: begin
                    d[a*128 + bt] = ~d[a*128 + bt];
                    d[b*128 + bt] = ~d[b*128 + bt];
                end
                3: p[bt] = ~p[bt];
                4: begin
                    d[a*128 + bt] = ~d[a*128 + bt];
                    cc[a*8 +: 8] = m_crc(d[a*128 +: 128]);
                end
                5: cc[a*8 +: 8] = cc[a*8 +: 8] ^ 8'(1 << (bt % 8));
                6: pc = pc ^ 8'h80;
                7: begin
                    d[a*128 + bt] = ~d[a*128 + bt];
                    p[bt] = ~p[bt];
                end
                default: begin
                end
            endcase
            run(d, cc, p, pc, $urandom_range(0, 3), 1'b0, 2'b00, 3'd0, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
